sector_deserializer: RTL

//  Sits directly downstream of DataSeparator: consumes its wr_clock/wr_data bit stream.

---
 rtl/hawk_pkg.sv | 24 ++
 rtl/crc16_serial.sv | 25 ++
 rtl/sector_deserializer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hawk_pkg.sv
// Shared types, default constants and the serial CRC-16 step for the sector deserializer.
package hawk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      DATA = 2'd2,
      CRC  = 2'd3
   } sect_state_t;

   localparam int          HAWK_WORD_BITS    = 16;
   localparam int          HAWK_SECTOR_WORDS = 256;
   localparam logic [15:0] HAWK_CRC_POLY     = 16'h8005;

   // One MSB-first CRC shift: feedback is the outgoing MSB xor the incoming bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        din,
                                              input logic [15:0] poly);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_serial.sv
// Serial CRC-16 LFSR advancing one bit per bit_en; clr wins over bit_en.
module crc16_serial
   import hawk_pkg::*;
#(
   parameter logic [15:0] POLY = HAWK_CRC_POLY
) (
   input  logic        hf_clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        bit_en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   always_ff @(posedge hf_clk) begin
      if (!rst_n) begin
         crc <= 16'h0000;
      end else if (clr) begin
         crc <= 16'h0000;
      end else if (bit_en) begin
         crc <= crc16_step(crc, bit_in, POLY);
      end
   end

endmodule

// File: rtl/sector_deserializer.sv
// Finds the sector sync in the DataSeparator bit stream, packs words MSB-first,
// checks the trailing CRC-16 and flags bit timeouts.
//
// state | meaning
// IDLE  | block disabled, waiting for en
// HUNT  | counting preamble zeros, waiting for the sync '1'
// DATA  | assembling SECTOR_WORDS data words
// CRC   | clocking the trailing CRC field through the checker
module sector_deserializer
   import hawk_pkg::*;
#(
   parameter int          WORD_BITS    = HAWK_WORD_BITS,
   parameter int          SECTOR_WORDS = HAWK_SECTOR_WORDS,
   parameter int          PREAMBLE_MIN = 8,
   parameter int          BIT_TIMEOUT  = 64,
   parameter logic [15:0] CRC_POLY     = HAWK_CRC_POLY
) (
   input  logic                 hf_clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 wr_clock,
   input  logic                 wr_data,
   output logic [WORD_BITS-1:0] word_out,
   output logic                 word_valid,
   output logic                 sync_found,
   output logic                 sector_done,
   output logic                 crc_ok,
   output logic                 err_timeout,
   output logic                 busy
);

   localparam int BC_W = $clog2(WORD_BITS);
   localparam int WC_W = $clog2(SECTOR_WORDS + 1);
   localparam int IC_W = $clog2(BIT_TIMEOUT + 1);
   localparam int ZC_W = $clog2(PREAMBLE_MIN + 1);

   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_BITS - 1);
   localparam logic [WC_W-1:0] WORD_LAST = WC_W'(SECTOR_WORDS - 1);
   localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(BIT_TIMEOUT - 1);
   localparam logic [ZC_W-1:0] ZERO_MAX  = ZC_W'(PREAMBLE_MIN);

   sect_state_t          state;
   logic                 wr_clock_q;
   logic [BC_W-1:0]      bit_cnt;
   logic [WC_W-1:0]      word_cnt;
   logic [IC_W-1:0]      idle_cnt;
   logic [ZC_W-1:0]      zero_cnt;
   logic [WORD_BITS-2:0] shreg;
   logic [15:0]          crc_q;
   logic [15:0]          crc_after;
   logic                 bit_evt, in_frame, tmo_fire, take_bit, sync_acc;

   assign bit_evt   = wr_clock & ~wr_clock_q;
   assign in_frame  = (state == DATA) || (state == CRC);
   // The timeout wins over a bit arriving in the same cycle; that bit is dropped.
   assign tmo_fire  = en && in_frame && (idle_cnt == IDLE_LAST);
   assign take_bit  = en && in_frame && bit_evt && !tmo_fire;
   assign sync_acc  = en && (state == HUNT) && bit_evt && wr_data && (zero_cnt >= ZERO_MAX);
   assign crc_after = crc16_step(crc_q, wr_data, CRC_POLY);

   crc16_serial #(.POLY(CRC_POLY)) u_crc (
      .hf_clk (hf_clk),
      .rst_n  (rst_n),
      .clr    (sync_acc),
      .bit_en (take_bit),
      .bit_in (wr_data),
      .crc    (crc_q)
   );

   always_ff @(posedge hf_clk) begin
      word_valid  <= 1'b0;
      sync_found  <= 1'b0;
      sector_done <= 1'b0;
      err_timeout <= 1'b0;
      if (!rst_n) begin
         state      <= IDLE;
         wr_clock_q <= 1'b0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         idle_cnt   <= '0;
         zero_cnt   <= '0;
         shreg      <= '0;
         word_out   <= '0;
         crc_ok     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wr_clock_q <= wr_clock;
         if (!en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            idle_cnt <= '0;
            zero_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= HUNT;
                  zero_cnt <= '0;
               end
               HUNT: begin
                  if (bit_evt) begin
                     if (!wr_data) begin
                        if (zero_cnt < ZERO_MAX) zero_cnt <= zero_cnt + 1'b1;
                     end else if (sync_acc) begin
                        state      <= DATA;
                        sync_found <= 1'b1;
                        crc_ok     <= 1'b0;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        idle_cnt   <= '0;
                        zero_cnt   <= '0;
                     end else begin
                        zero_cnt <= '0;
                     end
                  end
               end
               DATA, CRC: begin
                  if (tmo_fire) begin
                     state       <= HUNT;
                     err_timeout <= 1'b1;
                     busy        <= 1'b0;
                     bit_cnt     <= '0;
                     word_cnt    <= '0;
                     idle_cnt    <= '0;
                     zero_cnt    <= '0;
                  end else if (bit_evt) begin
                     idle_cnt <= '0;
                     bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                     if (state == DATA) begin
                        shreg <= {shreg[WORD_BITS-3:0], wr_data};
                        if (bit_cnt == BIT_LAST) begin
                           word_out   <= {shreg, wr_data};
                           word_valid <= 1'b1;
                           if (word_cnt == WORD_LAST) begin
                              state    <= CRC;
                              word_cnt <= '0;
                           end else begin
                              word_cnt <= word_cnt + 1'b1;
                           end
                        end
                     end else if (bit_cnt == BIT_LAST) begin
                        state       <= HUNT;
                        crc_ok      <= (crc_after == 16'h0000);
                        sector_done <= 1'b1;
                        busy        <= 1'b0;
                        zero_cnt    <= '0;
                     end
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
